control_barrera: RTL and testbench
==================================

Name: control_barrera

Overview:
- Single-lane barrier controller for the car-park occupancy datapath.
- Takes debounced entry/exit requests and a debounced pass sensor, and arbitrates the one lane between the entry and exit directions.
- Drives the barrier, and emits one-cycle INC/DEC pulses to the occupancy counter. Respects that counter's full/empty flags.
- Sits between the debouncers and the occupancy counter, in the 12 MHz CLK domain.

Parameters:
- TIMEOUT, 12000000: cycles in OPEN waiting for PASO before aborting (1 s at 12 MHz).
- CLOSE_HOLD, 6000000: cycles the barrier stays closed (lockout) after each cycle, before new requests are accepted.
- TMR_W, 24: width of the shared timer. Must hold max(TIMEOUT, CLOSE_HOLD)-1.

Ports:
- CLK  in  1  system clock, 12 MHz.
- RST  in  1  asynchronous reset, active-high.
- REQ_IN  in  1  entry request, debounced level.
- REQ_OUT  in  1  exit request, debounced level.
- PASO  in  1  vehicle-in-lane sensor, debounced level.
- LLENO  in  1  occupancy counter full flag.
- VACIO  in  1  occupancy counter empty flag (count == 0).
- GATE  out  1  barrier open command.
- GNT_IN  out  1  entry direction granted (level).
- GNT_OUT  out  1  exit direction granted (level).
- INC  out  1  one-cycle pulse: completed entry.
- DEC  out  1  one-cycle pulse: completed exit.
- TOUT  out  1  one-cycle pulse: aborted cycle (no vehicle passed).
- ESTADO  out  2  current FSM state code.

Behaviour:
- Reset (async, RST=1): state IDLE, timer 0, dir register 0, last_dir = OUT. All outputs 0. Reset mid-operation aborts immediately with no INC/DEC/TOUT pulse.
- Registered outputs: every output is registered, so it changes one CLK after the state or event that causes it.
- State codes: IDLE=0, OPEN=1, PASS=2, CLOSE=3.
- IDLE:
  - GATE=0. Entry request is valid when REQ_IN && !LLENO; exit request is valid when REQ_OUT && !VACIO.
  - One valid request: grant it. Both valid: grant the direction opposite last_dir (round-robin; after reset, entry wins first).
  - On grant: latch dir, update last_dir, clear timer, go to OPEN.
  - No valid request: stay in IDLE. PASO in IDLE is ignored and does not count.
- OPEN:
  - GATE=1; GNT_IN or GNT_OUT asserted per dir. Timer increments each cycle.
  - PASO=1: go to PASS (PASO takes precedence if it coincides with timeout).
  - Timer == TIMEOUT-1 with PASO=0: TOUT pulse, clear timer, go to CLOSE; no INC/DEC.
  - Requests dropping or LLENO/VACIO changing while in OPEN are ignored; the grant holds.
- PASS:
  - GATE=1, grant held, no timeout (a stuck vehicle keeps the barrier open).
  - PASO falling to 0: one-cycle INC if dir=IN, or DEC if dir=OUT. Clear timer, go to CLOSE.
- CLOSE:
  - GATE=0, grants 0. Timer counts; at CLOSE_HOLD-1 go to IDLE.
  - Requests are not sampled until back in IDLE (level requests held through CLOSE are served then).
- Invariants:
  - INC, DEC and TOUT are mutually exclusive, at most one pulse per barrier cycle.
  - GNT_IN and GNT_OUT are never both 1.
  - GATE=1 only in OPEN or PASS.
- Timer: unsigned TMR_W-bit, cleared on every state entry, never wraps (the compare fires first).

Optional Feature:
- Macro: ABORT_CNT_EN.
- Defined: adds output port ABORTS [7:0], the count of TOUT pulses.
  - Resets to 0 on RST.
  - Increments on each TOUT and saturates at 255.
- Undefined: no ABORTS port and no counter logic. All other behaviour is identical.

Test Plan (TIMEOUT=8, CLOSE_HOLD=4):
1. Reset with REQ_IN=1 held, then release RST, LLENO=0 -> OPEN within 2 cycles, GATE=1, GNT_IN=1. PASO high 3 cycles then low -> INC single pulse, GATE=0, CLOSE lasts 4 cycles, then IDLE.
2. REQ_IN=REQ_OUT=1, LLENO=VACIO=0, complete three cycles -> grant order IN, OUT, IN. INC, DEC, INC pulses in that order; GNT_IN/GNT_OUT never overlap.
3. REQ_IN=1, no PASO -> GATE=1 for exactly 8 cycles, then TOUT pulse, no INC. With ABORT_CNT_EN, ABORTS goes 0->1; after 256 aborts it stays at 255.
4. LLENO=1 with REQ_IN=1, REQ_OUT=0 -> stays in IDLE, GATE=0. Then VACIO=1 with REQ_OUT=1 -> no grant. Then LLENO=0 -> entry granted next cycle.
5. PASO=1 while in IDLE -> no state change, no pulses. PASO rising in the same cycle the timer hits 7 in OPEN -> PASS, no TOUT.
6. Assert RST during PASS -> GATE, grants and ESTADO go to 0 immediately (asynchronous), no DEC/INC emitted. After release, IDLE resumes; if both requests are valid, entry wins.

Source files
------------

// File: rtl/control_barrera.sv
// rtl/control_barrera.sv - single-lane barrier arbiter/controller driving occupancy INC/DEC pulses.
// Optional ABORT_CNT_EN adds ABORTS, a saturating count of TOUT pulses.
module control_barrera #(
  parameter int TIMEOUT    = 12000000,
  parameter int CLOSE_HOLD = 6000000,
  parameter int TMR_W      = 24
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_IN,
  input  logic       REQ_OUT,
  input  logic       PASO,
  input  logic       LLENO,
  input  logic       VACIO,
  output logic       GATE,
  output logic       GNT_IN,
  output logic       GNT_OUT,
  output logic       INC,
  output logic       DEC,
  output logic       TOUT,
  output logic [1:0] ESTADO
`ifdef ABORT_CNT_EN
  ,
  output logic [7:0] ABORTS
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OPEN  = 2'd1,
    S_PASS  = 2'd2,
    S_CLOSE = 2'd3
  } state_t;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;
  localparam logic [TMR_W-1:0] LP_TO_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LP_CH_LAST = TMR_W'(CLOSE_HOLD - 1);

  state_t           r_state, w_state_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_last_dir, w_last_dir_nxt;
  logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
  logic             r_gate, r_gnt_in, r_gnt_out, r_inc, r_dec, r_tout;
  logic             w_gate_nxt, w_inc_nxt, w_dec_nxt, w_tout_nxt;
  logic             w_in_ok, w_out_ok;

  assign w_in_ok  = REQ_IN && !LLENO;
  assign w_out_ok = REQ_OUT && !VACIO;

  always_comb begin
    w_state_nxt    = r_state;
    w_dir_nxt      = r_dir;
    w_last_dir_nxt = r_last_dir;
    w_tmr_nxt      = r_tmr;
    w_inc_nxt      = 1'b0;
    w_dec_nxt      = 1'b0;
    w_tout_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Round-robin on contention: serve the direction not served last time.
        if (w_in_ok && (!w_out_ok || r_last_dir == DIR_OUT)) begin
          w_dir_nxt      = DIR_IN;
          w_last_dir_nxt = DIR_IN;
          w_tmr_nxt      = '0;
          w_state_nxt    = S_OPEN;
        end else if (w_out_ok) begin
          w_dir_nxt      = DIR_OUT;
          w_last_dir_nxt = DIR_OUT;
          w_tmr_nxt      = '0;
          w_state_nxt    = S_OPEN;
        end
      end
      S_OPEN: begin
        if (PASO) begin
          w_tmr_nxt   = '0;
          w_state_nxt = S_PASS;
        end else if (r_tmr == LP_TO_LAST) begin
          w_tout_nxt  = 1'b1;
          w_tmr_nxt   = '0;
          w_state_nxt = S_CLOSE;
        end else begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end
      S_PASS: begin
        if (!PASO) begin
          w_inc_nxt   = (r_dir == DIR_IN);
          w_dec_nxt   = (r_dir == DIR_OUT);
          w_tmr_nxt   = '0;
          w_state_nxt = S_CLOSE;
        end
      end
      S_CLOSE: begin
        if (r_tmr == LP_CH_LAST) begin
          w_tmr_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end
      default: begin
        w_tmr_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
    w_gate_nxt = (w_state_nxt == S_OPEN) || (w_state_nxt == S_PASS);
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_dir      <= DIR_IN;
      r_last_dir <= DIR_OUT;
      r_tmr      <= '0;
      r_gate     <= 1'b0;
      r_gnt_in   <= 1'b0;
      r_gnt_out  <= 1'b0;
      r_inc      <= 1'b0;
      r_dec      <= 1'b0;
      r_tout     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dir      <= w_dir_nxt;
      r_last_dir <= w_last_dir_nxt;
      r_tmr      <= w_tmr_nxt;
      r_gate     <= w_gate_nxt;
      r_gnt_in   <= w_gate_nxt && (w_dir_nxt == DIR_IN);
      r_gnt_out  <= w_gate_nxt && (w_dir_nxt == DIR_OUT);
      r_inc      <= w_inc_nxt;
      r_dec      <= w_dec_nxt;
      r_tout     <= w_tout_nxt;
    end
  end

  assign GATE    = r_gate;
  assign GNT_IN  = r_gnt_in;
  assign GNT_OUT = r_gnt_out;
  assign INC     = r_inc;
  assign DEC     = r_dec;
  assign TOUT    = r_tout;
  assign ESTADO  = r_state;

`ifdef ABORT_CNT_EN
  logic [7:0] r_aborts;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_aborts <= 8'd0;
    end else if (w_tout_nxt && r_aborts != 8'hFF) begin
      r_aborts <= r_aborts + 8'd1;
    end
  end

  assign ABORTS = r_aborts;
`endif

endmodule

// File: tb/tb_control_barrera.sv
// tb/tb_control_barrera.sv - scoreboard bench for control_barrera (TIMEOUT=8, CLOSE_HOLD=4).
module tb_control_barrera;

  localparam int EV_GIN  = 1;
  localparam int EV_GOUT = 2;
  localparam int EV_INC  = 3;
  localparam int EV_DEC  = 4;
  localparam int EV_TOUT = 5;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ_IN = 1'b0, REQ_OUT = 1'b0, PASO = 1'b0, LLENO = 1'b0, VACIO = 1'b0;
  logic       GATE, GNT_IN, GNT_OUT, INC, DEC, TOUT;
  logic [1:0] ESTADO;
`ifdef ABORT_CNT_EN
  logic [7:0] ABORTS;
`endif

  int total = 0;
  int bad   = 0;
  int sb[$];
  logic p_gi = 1'b0, p_go = 1'b0;

  control_barrera #(.TIMEOUT(8), .CLOSE_HOLD(4), .TMR_W(24)) dut (
    .CLK(CLK), .RST(RST), .REQ_IN(REQ_IN), .REQ_OUT(REQ_OUT), .PASO(PASO),
    .LLENO(LLENO), .VACIO(VACIO), .GATE(GATE), .GNT_IN(GNT_IN), .GNT_OUT(GNT_OUT),
    .INC(INC), .DEC(DEC), .TOUT(TOUT), .ESTADO(ESTADO)
`ifdef ABORT_CNT_EN
    , .ABORTS(ABORTS)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_pop(input int code);
    int exp;
    if (sb.size() == 0) begin
      chk($sformatf("sb_unexpected_ev%0d", code), sb.size(), 1);
    end else begin
      exp = sb.pop_front();
      chk("sb_event", code, exp);
    end
  endtask

  always @(negedge CLK) begin
    chk("inv_gnt_overlap", GNT_IN & GNT_OUT, 0);
    chk("inv_gate_state", GATE && !(ESTADO == 2'd1 || ESTADO == 2'd2), 0);
    chk("inv_pulse_excl", (32'(INC) + 32'(DEC) + 32'(TOUT)) > 1, 0);
    if (GNT_IN && !p_gi) sb_pop(EV_GIN);
    if (GNT_OUT && !p_go) sb_pop(EV_GOUT);
    if (INC) sb_pop(EV_INC);
    if (DEC) sb_pop(EV_DEC);
    if (TOUT) sb_pop(EV_TOUT);
    p_gi <= GNT_IN;
    p_go <= GNT_OUT;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int max, input string tag);
    int n = 0;
    while (ESTADO !== s && n < max) begin
      tick();
      n++;
    end
    chk(tag, ESTADO, s);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic run_abort();
    REQ_IN = 1'b1;
    sb.push_back(EV_GIN);
    sb.push_back(EV_TOUT);
    wait_state(2'd1, 4, "ab_open");
    REQ_IN = 1'b0;
    wait_state(2'd0, 30, "ab_idle");
  endtask

  initial begin
    int n;
    // 1: entry after reset, full pass, close length
    REQ_IN = 1'b1;
    #2;
    chk("rst_gate", GATE, 0);
    chk("rst_gnt", {GNT_IN, GNT_OUT}, 0);
    chk("rst_pulses", {INC, DEC, TOUT}, 0);
    chk("rst_estado", ESTADO, 0);
    sb.push_back(EV_GIN);
    sb.push_back(EV_INC);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    wait_state(2'd1, 2, "t1_open");
    chk("t1_gate", GATE, 1);
    chk("t1_gnt_in", GNT_IN, 1);
    REQ_IN = 1'b0;
    PASO = 1'b1;
    repeat (3) tick();
    chk("t1_pass", ESTADO, 2);
    PASO = 1'b0;
    tick();
    chk("t1_inc", INC, 1);
    chk("t1_gate_closed", GATE, 0);
    chk("t1_close", ESTADO, 3);
    n = 0;
    while (ESTADO === 2'd3 && n < 20) begin
      n++;
      tick();
    end
    chk("t1_close_len", n, 4);
    chk("t1_idle", ESTADO, 0);

    // 2: round-robin under contention from a fresh reset
    do_reset();
    REQ_IN = 1'b1;
    REQ_OUT = 1'b1;
    sb.push_back(EV_GIN);  sb.push_back(EV_INC);
    sb.push_back(EV_GOUT); sb.push_back(EV_DEC);
    sb.push_back(EV_GIN);  sb.push_back(EV_INC);
    for (int k = 0; k < 3; k++) begin
      wait_state(2'd1, 10, "t2_open");
      PASO = 1'b1;
      tick();
      tick();
      PASO = 1'b0;
      wait_state(2'd3, 4, "t2_close");
    end
    REQ_IN = 1'b0;
    REQ_OUT = 1'b0;
    wait_state(2'd0, 10, "t2_idle");

    // 3: timeout without a vehicle
`ifdef ABORT_CNT_EN
    chk("t3_aborts0", ABORTS, 0);
`endif
    REQ_IN = 1'b1;
    sb.push_back(EV_GIN);
    sb.push_back(EV_TOUT);
    wait_state(2'd1, 4, "t3_open");
    REQ_IN = 1'b0;
    n = 0;
    while (GATE === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("t3_gate_len", n, 8);
    chk("t3_tout", TOUT, 1);
    chk("t3_no_inc", INC, 0);
    wait_state(2'd0, 10, "t3_idle");
`ifdef ABORT_CNT_EN
    chk("t3_aborts1", ABORTS, 1);
    for (int k = 0; k < 255; k++) run_abort();
    chk("t3_aborts_sat", ABORTS, 255);
`endif

    // 4: full/empty flags block requests
    LLENO = 1'b1;
    REQ_IN = 1'b1;
    repeat (4) tick();
    chk("t4_full_idle", ESTADO, 0);
    chk("t4_full_gate", GATE, 0);
    VACIO = 1'b1;
    REQ_OUT = 1'b1;
    repeat (4) tick();
    chk("t4_empty_idle", ESTADO, 0);
    chk("t4_empty_gnt", {GNT_IN, GNT_OUT}, 0);
    sb.push_back(EV_GIN);
    sb.push_back(EV_TOUT);
    LLENO = 1'b0;
    tick();
    chk("t4_open", ESTADO, 1);
    chk("t4_gnt_in", GNT_IN, 1);
    REQ_IN = 1'b0;
    REQ_OUT = 1'b0;
    VACIO = 1'b0;
    wait_state(2'd0, 20, "t4_idle");

    // 5: PASO in IDLE ignored; PASO at last timeout cycle wins
    PASO = 1'b1;
    repeat (4) tick();
    chk("t5_idle_paso", ESTADO, 0);
    chk("t5_idle_pulses", {INC, DEC, TOUT}, 0);
    PASO = 1'b0;
    REQ_IN = 1'b1;
    sb.push_back(EV_GIN);
    sb.push_back(EV_INC);
    tick();
    chk("t5_open", ESTADO, 1);
    REQ_IN = 1'b0;
    repeat (7) tick();
    chk("t5_still_open", ESTADO, 1);
    PASO = 1'b1;
    tick();
    chk("t5_pass", ESTADO, 2);
    chk("t5_no_tout", TOUT, 0);
    PASO = 1'b0;
    tick();
    chk("t5_inc", INC, 1);
    wait_state(2'd0, 10, "t5_idle");

    // 6: asynchronous reset during PASS
    REQ_OUT = 1'b1;
    sb.push_back(EV_GOUT);
    tick();
    chk("t6_open", ESTADO, 1);
    PASO = 1'b1;
    tick();
    chk("t6_pass", ESTADO, 2);
    #2;
    RST = 1'b1;
    #1;
    chk("t6_rst_gate", GATE, 0);
    chk("t6_rst_gnt", {GNT_IN, GNT_OUT}, 0);
    chk("t6_rst_estado", ESTADO, 0);
    PASO = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("t6_rst_pulses", {INC, DEC, TOUT}, 0);
    REQ_IN = 1'b1;
    sb.push_back(EV_GIN);
    sb.push_back(EV_TOUT);
    RST = 1'b0;
    tick();
    chk("t6_entry_wins", GNT_IN, 1);
    REQ_IN = 1'b0;
    REQ_OUT = 1'b0;
    wait_state(2'd0, 20, "t6_idle");
    tick();

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(50000 * 10);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
